// File: rtl/mux_key_pkg.sv
// Shared helpers for mux_key_with_default: entry width and field offsets
// used when packing or slicing the lut bus.
package mux_key_pkg;

    function automatic int entry_w(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

    // LSB position of entry idx's data field inside lut.
    function automatic int data_lo(input int idx, input int key_len, input int data_len);
        return idx * entry_w(key_len, data_len);
    endfunction

    // LSB position of entry idx's key field; the key sits above the data.
    function automatic int key_lo(input int idx, input int key_len, input int data_len);
        return idx * entry_w(key_len, data_len) + data_len;
    endfunction

endpackage

// File: rtl/mux_key_match.sv
// Combinational table search: returns the data of the lowest-index entry
// whose key equals the input key, plus a match flag.
module mux_key_match
    import mux_key_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                           key,
    input  logic [NR_KEY*entry_w(KEY_LEN, DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                          data,
    output logic                                         match
);

    logic [KEY_LEN-1:0]  keys  [NR_KEY];
    logic [DATA_LEN-1:0] datas [NR_KEY];

    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
            localparam int KLO = key_lo(gi, KEY_LEN, DATA_LEN);
            localparam int DLO = data_lo(gi, KEY_LEN, DATA_LEN);
            assign keys[gi]  = lut[KLO +: KEY_LEN];
            assign datas[gi] = lut[DLO +: DATA_LEN];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        data  = '0;
        match = 1'b0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (key == keys[i]) begin
                data  = datas[i];
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_key_with_default.sv
// Registered key-lookup mux with default value, one cycle of latency.
// Define MUXKEY_HIT_EN to add the registered hit output.
module mux_key_with_default
    import mux_key_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [KEY_LEN-1:0]                           key,
    input  logic [DATA_LEN-1:0]                          default_out,
    input  logic [NR_KEY*entry_w(KEY_LEN, DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                          out
`ifdef MUXKEY_HIT_EN
    ,
    output logic                                         hit
`endif
);

    logic [DATA_LEN-1:0] match_data;
    logic                match;
    logic [DATA_LEN-1:0] out_next;

    mux_key_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_match (
        .key   (key),
        .lut   (lut),
        .data  (match_data),
        .match (match)
    );

    assign out_next = match ? match_data : default_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

`ifdef MUXKEY_HIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else begin
            hit <= match;
        end
    end
`endif

endmodule

// File: tb/tb_mux_key_with_default.sv
// Bench for mux_key_with_default: three instances (opcode table, 3-entry
// table, duplicate-key table) checked against a queue of expected results.
module tb_mux_key_with_default;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: NR_KEY=1, KEY_LEN=7, DATA_LEN=3
    logic [6:0]  key_a;
    logic [2:0]  dflt_a;
    logic [9:0]  lut_a;
    logic [2:0]  out_a;
    // Instance B: NR_KEY=3, KEY_LEN=2, DATA_LEN=4
    logic [1:0]  key_b;
    logic [3:0]  dflt_b;
    logic [17:0] lut_b;
    logic [3:0]  out_b;
    // Instance C: duplicate keys, NR_KEY=2, KEY_LEN=2, DATA_LEN=4
    logic [1:0]  key_c;
    logic [3:0]  dflt_c;
    logic [11:0] lut_c;
    logic [3:0]  out_c;
`ifdef MUXKEY_HIT_EN
    logic hit_a, hit_b, hit_c;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [3:0] oa;
        logic       ha;
        logic [3:0] ob;
        logic       hb;
        logic [3:0] oc;
        logic       hc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mux_key_with_default #(.NR_KEY(1), .KEY_LEN(7), .DATA_LEN(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .default_out(dflt_a), .lut(lut_a), .out(out_a)
`ifdef MUXKEY_HIT_EN
        , .hit(hit_a)
`endif
    );

    mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_b), .default_out(dflt_b), .lut(lut_b), .out(out_b)
`ifdef MUXKEY_HIT_EN
        , .hit(hit_b)
`endif
    );

    mux_key_with_default #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .key(key_c), .default_out(dflt_c), .lut(lut_c), .out(out_c)
`ifdef MUXKEY_HIT_EN
        , .hit(hit_c)
`endif
    );

    // Reference models: {hit, out} from the test-plan tables.
    function automatic logic [4:0] model_a(input logic [6:0] k, input logic [2:0] d);
        if (k == 7'b0010011) return {1'b1, 4'b0000};
        return {1'b0, 1'b0, d};
    endfunction

    function automatic logic [4:0] model_b(input logic [1:0] k, input logic [3:0] d);
        case (k)
            2'd0:    return {1'b1, 4'hA};
            2'd1:    return {1'b1, 4'hB};
            2'd2:    return {1'b1, 4'hC};
            default: return {1'b0, d};
        endcase
    endfunction

    function automatic logic [4:0] model_c(input logic [1:0] k, input logic [3:0] d);
        if (k == 2'd1) return {1'b1, 4'h3};
        return {1'b0, d};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push expectation for current inputs, clock once, pop and compare.
    task automatic step(input string tag);
        exp_t e;
        e.tag = tag;
        {e.ha, e.oa} = model_a(key_a, dflt_a);
        {e.hb, e.ob} = model_b(key_b, dflt_b);
        {e.hc, e.oc} = model_c(key_c, dflt_c);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".out_a"}, {1'b0, out_a}, e.oa);
        check({e.tag, ".out_b"}, out_b, e.ob);
        check({e.tag, ".out_c"}, out_c, e.oc);
`ifdef MUXKEY_HIT_EN
        check({e.tag, ".hit_a"}, {3'b0, hit_a}, {3'b0, e.ha});
        check({e.tag, ".hit_b"}, {3'b0, hit_b}, {3'b0, e.hb});
        check({e.tag, ".hit_c"}, {3'b0, hit_c}, {3'b0, e.hc});
`endif
        $display("step %s: key_a=%b out_a=%b key_b=%0d out_b=%h key_c=%0d out_c=%h",
                 tag, key_a, out_a, key_b, out_b, key_c, out_c);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".out_a"}, {1'b0, out_a}, 4'h0);
        check({tag, ".out_b"}, out_b, 4'h0);
        check({tag, ".out_c"}, out_c, 4'h0);
`ifdef MUXKEY_HIT_EN
        check({tag, ".hit_a"}, {3'b0, hit_a}, 4'h0);
        check({tag, ".hit_b"}, {3'b0, hit_b}, 4'h0);
        check({tag, ".hit_c"}, {3'b0, hit_c}, 4'h0);
`endif
        $display("reset %s: out_a=%b out_b=%h out_c=%h", tag, out_a, out_b, out_c);
    endtask

    initial begin
        rst_n  = 1'b1;
        lut_a  = {7'b0010011, 3'b000};
        lut_b  = {2'd2, 4'hC, 2'd1, 4'hB, 2'd0, 4'hA};
        lut_c  = {2'd1, 4'h9, 2'd1, 4'h3};
        key_a  = 7'b0010011;
        dflt_a = 3'b111;
        key_b  = 2'd0;
        dflt_b = 4'h5;
        key_c  = 2'd1;
        dflt_c = 4'h6;
        #2 rst_n = 1'b0;
        #1 check_reset("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-entry opcode table
        key_a = 7'b0010011; step("a_hit");
        key_a = 7'b0110011; step("a_miss");

        // Multi-entry walk and duplicate-key priority
        key_b = 2'd0; key_c = 2'd1; step("b_k0");
        key_b = 2'd1; key_c = 2'd0; step("b_k1");
        key_b = 2'd2; key_c = 2'd1; step("b_k2");
        key_b = 2'd3; key_c = 2'd3; step("b_k3");

        // Mid-stream async reset with matches present; prior outputs nonzero
        key_a = 7'b0110011; key_b = 2'd2; step("pre_rst");
        key_a = 7'b0010011;
        #2 rst_n = 1'b0;
        #1 check_reset("mid_async");
        @(posedge clk);
        #1 check_reset("mid_held");
        rst_n = 1'b1;
        step("post_rel");

        // Back-to-back match/miss alternation with changing defaults
        for (int i = 0; i < 10; i++) begin
            key_a  = (i % 2 == 0) ? 7'b0110011 : 7'b0010011;
            key_b  = (i % 2 == 0) ? 2'd3 : 2'(i % 3);
            key_c  = (i % 2 == 0) ? 2'd2 : 2'd1;
            dflt_a = 3'($urandom_range(0, 7));
            dflt_b = 4'($urandom_range(0, 15));
            dflt_c = 4'($urandom_range(0, 15));
            step($sformatf("b2b%0d", i));
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
